// File: rtl/systolic_pe_acc.sv
// systolic_pe_acc: one processing element of a systolic array.
// Each valid beat does one multiply-accumulate and forwards its operands to the
// right and down neighbours. Products are grouped into tiles of k_len beats.
// A tile can start from a bias value, can saturate or wrap on overflow, and
// keeps a sticky overflow flag. Tiles can run back-to-back. Global stall and
// flush let the array controller freeze or abort every PE in lockstep.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i, flush_i        global freeze / abort current tile
//   valid_i, a_i, b_i       operand beat
//   k_len_i, bias_en_i, c_i,
//   signed_i, sat_en_i      tile configuration, sampled on the first beat
//   a_o, b_o, valid_o       registered pass-through to the neighbours
//   res_o, ovf_o            last completed tile result and its overflow flag
//   res_valid_o             one-cycle pulse when res_o updates
//   busy_o                  a tile is in progress
module systolic_pe_acc #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 64,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned CNT_W      = $clog2(K_MAX + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [CNT_W-1:0]      k_len_i,
    input  logic                  bias_en_i,
    input  logic [ACC_WIDTH-1:0]  c_i,
    input  logic                  signed_i,
    input  logic                  sat_en_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  valid_o,
    output logic [ACC_WIDTH-1:0]  res_o,
    output logic                  res_valid_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned MSB    = ACC_WIDTH - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     keff_q;
    logic                 cfg_signed_q;
    logic                 cfg_sat_q;
    logic                 tile_ovf_q;

    logic                 beat;
    logic                 in_idle;
    logic [CNT_W-1:0]     k_clip;
    logic [CNT_W-1:0]     k_in;
    logic [CNT_W-1:0]     keff_cur;
    logic [CNT_W-1:0]     cnt_cur;
    logic                 sgn_cur;
    logic                 sat_cur;
    logic [ACC_WIDTH-1:0] base;
    logic                 ovf_in;
    logic [PROD_W-1:0]    a_x;
    logic [PROD_W-1:0]    b_x;
    logic [PROD_W-1:0]    prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf_beat;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 flag_next;
    logic                 last_beat;

    // State register; busy mirrors the state it is entering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d == ST_ACC);
        end
    end

    // Next-state logic: flush aborts, a last beat closes the tile.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else if (beat) begin
            state_d = last_beat ? ST_IDLE : ST_ACC;
        end
    end

    // MAC datapath: in IDLE the tile config comes straight from the inputs.
    always_comb begin
        beat     = valid_i & ~stall_i & ~flush_i;
        in_idle  = (state_q == ST_IDLE);
        k_clip   = (k_len_i > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len_i;
        k_in     = (k_clip == '0) ? CNT_W'(1) : k_clip;
        keff_cur = in_idle ? k_in : keff_q;
        cnt_cur  = in_idle ? '0 : cnt_q;
        sgn_cur  = in_idle ? signed_i : cfg_signed_q;
        sat_cur  = in_idle ? sat_en_i : cfg_sat_q;
        base     = in_idle ? (bias_en_i ? c_i : '0) : acc_q;
        ovf_in   = in_idle ? 1'b0 : tile_ovf_q;

        // Sign/zero-extended operands let one unsigned multiplier serve both modes.
        a_x      = {{DATA_WIDTH{sgn_cur & a_i[DATA_WIDTH-1]}}, a_i};
        b_x      = {{DATA_WIDTH{sgn_cur & b_i[DATA_WIDTH-1]}}, b_i};
        prod     = a_x * b_x;
        prod_ext = sgn_cur ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);

        sum_full = {1'b0, base} + {1'b0, prod_ext};
        sum      = sum_full[MSB:0];
        ovf_beat = sgn_cur ? ((base[MSB] == prod_ext[MSB]) && (sum[MSB] != base[MSB]))
                           : sum_full[ACC_WIDTH];

        acc_next = sum;
        if (ovf_beat && sat_cur) begin
            if (sgn_cur) begin
                acc_next = prod_ext[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                acc_next = '1;
            end
        end
        flag_next = ovf_in | ovf_beat;
        last_beat = beat & (cnt_cur == keff_cur - CNT_W'(1));
    end

    // Datapath, result and pass-through registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_o          <= '0;
            b_o          <= '0;
            valid_o      <= 1'b0;
            res_o        <= '0;
            res_valid_o  <= 1'b0;
            ovf_o        <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            keff_q       <= CNT_W'(1);
            cfg_signed_q <= 1'b0;
            cfg_sat_q    <= 1'b0;
            tile_ovf_q   <= 1'b0;
        end else begin
            // Pass-through ignores flush and only obeys stall.
            if (!stall_i) begin
                a_o     <= a_i;
                b_o     <= b_i;
                valid_o <= valid_i;
            end
            if (flush_i) begin
                acc_q       <= '0;
                cnt_q       <= '0;
                tile_ovf_q  <= 1'b0;
                res_valid_o <= 1'b0;
            end else if (!stall_i) begin
                res_valid_o <= last_beat;
                if (beat) begin
                    if (in_idle) begin
                        keff_q       <= k_in;
                        cfg_signed_q <= signed_i;
                        cfg_sat_q    <= sat_en_i;
                    end
                    if (last_beat) begin
                        res_o      <= acc_next;
                        ovf_o      <= flag_next;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        tile_ovf_q <= 1'b0;
                    end else begin
                        acc_q      <= acc_next;
                        cnt_q      <= cnt_cur + CNT_W'(1);
                        tile_ovf_q <= flag_next;
                    end
                end
            end
        end
    end

endmodule
